rr_grant_index: RTL

- 16-requester round-robin arbiter producing a registered 4-bit grant index with valid/ready handshake.
- Sits directly upstream of the 4-to-16 one-hot decoder. gnt_idx feeds the decoder's binary input, and the decoder's 16-bit output is the one-hot grant vector.
- Fairness comes from a rotating priority pointer that advances past each accepted grant.

---
 rtl/rr_grant_index_if.sv | 18 +
 rtl/rr_grant_index.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rr_grant_index_if.sv
// Grant handshake bundle for rr_grant_index: request vector in, registered grant index out.
// Carries stall_cnt only when RR_STALL_CNT_EN is defined.
interface rr_grant_index_if;
  logic [15:0] req;
  logic        gnt_ready;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [3:0]  ptr;
`ifdef RR_STALL_CNT_EN
  logic [7:0]  stall_cnt;

  modport master (output req, gnt_ready, input gnt_valid, gnt_idx, ptr, stall_cnt);
  modport slave  (input req, gnt_ready, output gnt_valid, gnt_idx, ptr, stall_cnt);
`else
  modport master (output req, gnt_ready, input gnt_valid, gnt_idx, ptr);
  modport slave  (input req, gnt_ready, output gnt_valid, gnt_idx, ptr);
`endif
endinterface

// File: rtl/rr_grant_index.sv
// 16-requester round-robin arbiter with a registered 4-bit grant index and valid/ready handshake.
// Optional macro RR_STALL_CNT_EN adds a saturating backpressure counter (stall_cnt).
module rr_grant_index #(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_grant_index_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]       r_state;
  logic             r_gnt_valid;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_ptr;

  logic [0:0]       w_state_nxt;
  logic             w_valid_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_any_req;
  logic             w_xfer;
  logic [IDX_W-1:0] w_idx_inc;

  // First set bit of req at or above start, wrapping from the top bit back to bit 0.
  function automatic logic [IDX_W-1:0] f_search(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign w_any_req = |bus.req;
  assign w_xfer    = r_gnt_valid & bus.gnt_ready;
  assign w_idx_inc = r_gnt_idx + {{(IDX_W-1){1'b0}}, 1'b1};

  // Next-state decode; the offered index is frozen until the downstream accepts it.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_gnt_valid;
    w_idx_nxt   = r_gnt_idx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_idx_nxt   = f_search(bus.req, r_ptr);
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OFFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (bus.gnt_ready) begin
          w_ptr_nxt = w_idx_inc;
          if (w_any_req) begin
            w_idx_nxt = f_search(bus.req, w_idx_inc);
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_OFFER;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_ptr       <= {IDX_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.ptr       = r_ptr;

`ifdef RR_STALL_CNT_EN
  logic [7:0] r_stall_cnt;
  logic [7:0] w_stall_nxt;

  // Stall counter: counts offered-but-not-accepted cycles, saturating at 255.
  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (w_xfer) begin
      w_stall_nxt = 8'd0;
    end else if (r_gnt_valid && (r_stall_cnt != 8'hFF)) begin
      w_stall_nxt = r_stall_cnt + 8'd1;
    end else begin
      w_stall_nxt = r_stall_cnt;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 8'd0;
    end else begin
      r_stall_cnt <= w_stall_nxt;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
